// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encoding,
// default latencies and control state encoding.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_unit_if.sv
// E-stage to multiply/divide unit connection: operation request, operands,
// pipeline stall request and the architectural HI/LO values.
interface md_unit_if;
    import md_pkg::*;

    logic        start;
    md_op_t      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, md_use_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, md_use_D,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit {hi,lo} generator for MULT/MULTU/DIV/DIVU.
// Division by zero is flagged so the caller can suppress the writeback.
module md_calc
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        sgn_mul;
    logic        sgn_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        result   = '0;
        div_zero = (b == '0);
        sgn_mul  = (op == MD_MULT);
        sgn_div  = (op == MD_DIV);

        ext_a = sgn_mul ? {{32{a[31]}}, a} : {32'b0, a};
        ext_b = sgn_mul ? {{32{b[31]}}, b} : {32'b0, b};

        // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly
        mag_a = (sgn_div && a[31]) ? -a : a;
        mag_b = (sgn_div && b[31]) ? -b : b;
        quo   = div_zero ? '0 : mag_a / mag_b;
        rem   = div_zero ? '0 : mag_a % mag_b;

        case (op)
            MD_MULT, MD_MULTU: result = ext_a * ext_b;
            MD_DIV: begin
                result[63:32] = a[31] ? -rem : rem;
                result[31:0]  = (a[31] ^ b[31]) ? -quo : quo;
            end
            MD_DIVU: result = {rem, quo};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, sequences multi-cycle ops and
// raises the stall request toward the F/D/E pipeline registers.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    md_unit_if.slave    bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t        state;
    logic [CNT_W-1:0] count;
    logic [63:0]      result;
    logic             skip_wb;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      calc_result;
    logic             calc_div_zero;

    md_calc u_calc (
        .op       (bus.md_op),
        .a        (bus.rs_val),
        .b        (bus.rt_val),
        .result   (calc_result),
        .div_zero (calc_div_zero)
    );

    // Result is captured at the start edge; operands may change while busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MD_IDLE;
            count   <= '0;
            result  <= '0;
            skip_wb <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.start) begin
                        case (bus.md_op)
                            MD_MULT, MD_MULTU: begin
                                state   <= MD_RUN;
                                count   <= CNT_W'(MULT_CYCLES);
                                result  <= calc_result;
                                skip_wb <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                state   <= MD_RUN;
                                count   <= CNT_W'(DIV_CYCLES);
                                result  <= calc_result;
                                skip_wb <= calc_div_zero;
                            end
                            MD_MTHI: hi_q <= bus.rs_val;
                            MD_MTLO: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= MD_IDLE;
                        if (!skip_wb) begin
                            hi_q <= result[63:32];
                            lo_q <= result[31:0];
                        end
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign bus.busy     = (count != '0);
    assign bus.stall_md = bus.md_use_D & (bus.start | bus.busy);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO pairs are queued when an
// operation is issued and compared when busy falls.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [63:0] sb[$];
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        longint          sa;
        longint          sb_;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned ur;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (op)
            MD_MULT:  return 64'(sa * sb_);
            MD_MULTU: return 64'(ua * ub);
            MD_DIV: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {h, l};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {h, l};
        endcase
    endfunction

    // Issue a multi-cycle op, optionally pulse a second start at busy cycle inject_at
    task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int unsigned n, input bit use_d,
                          input int unsigned inject_at);
        int unsigned cycles;
        bit          done;
        logic [63:0] want;
        sb.push_back(exp);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.md_op    = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.md_use_D = use_d;
        #1;
        check({tag, "_start_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_start_stall"}, 64'(bus.stall_md), 64'(use_d));
        cycles = 0;
        done   = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (i == inject_at) begin
                bus.start  = 1'b1;
                bus.md_op  = MD_DIV;
                bus.rs_val = 32'd100;
                bus.rt_val = 32'd3;
            end else begin
                bus.start  = 1'b0;
                bus.md_op  = MD_NONE;
                bus.rs_val = $urandom;
                bus.rt_val = $urandom;
            end
            #1;
            if (bus.busy) begin
                cycles++;
                check({tag, "_hold"}, {bus.hi, bus.lo}, {hi_m, lo_m});
                check({tag, "_busy_stall"}, 64'(bus.stall_md), 64'(use_d));
            end else begin
                done = 1'b1;
                check({tag, "_busy_cycles"}, 64'(cycles), 64'(n));
                want = sb.pop_front();
                check({tag, "_hi"}, 64'(bus.hi), 64'(want[63:32]));
                check({tag, "_lo"}, 64'(bus.lo), 64'(want[31:0]));
                check({tag, "_end_stall"}, 64'(bus.stall_md), 64'(0));
                hi_m = want[63:32];
                lo_m = want[31:0];
            end
        end
        if (!done) begin
            check({tag, "_timeout"}, 64'(cycles), 64'(n));
            sb.delete();
        end
        bus.md_use_D = 1'b0;
    endtask

    // Single-cycle ops (MTHI/MTLO/NONE/reserved): busy must never rise
    task automatic short_op(input string tag, input md_op_t op, input logic [31:0] v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = v;
        bus.rt_val = $urandom;
        #1;
        check({tag, "_start_busy"}, 64'(bus.busy), 64'(0));
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        #1;
        if (op == MD_MTHI) hi_m = v;
        if (op == MD_MTLO) lo_m = v;
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_hi"}, 64'(bus.hi), 64'(hi_m));
        check({tag, "_lo"}, 64'(bus.lo), 64'(lo_m));
    endtask

    initial begin
        md_op_t      rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.md_op    = MD_NONE;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.md_use_D = 1'b1;
        hi_m         = '0;
        lo_m         = '0;

        #12;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_stall", 64'(bus.stall_md), 64'(0));
        @(negedge clk);
        reset        = 1'b1;
        bus.md_use_D = 1'b0;

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 5, 1'b1, 0);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5, 1'b0, 0);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 10, 1'b0, 0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b0, 0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 1'b0, 0);

        short_op("mthi", MD_MTHI, 32'h11);
        short_op("mtlo", MD_MTLO, 32'h22);
        run_op("div_zero", MD_DIV, 32'd5, 32'd0, 64'h0000_0011_0000_0022, 10, 1'b0, 0);
        short_op("nop_none", MD_NONE, 32'hDEAD_BEEF);
        short_op("nop_rsvd", MD_RSVD, 32'hCAFE_F00D);

        run_op("mult_inject", MD_MULT, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000, 5, 1'b1, 2);

        for (int k = 0; k < 6; k++) begin
            rop = md_op_t'(3'($urandom_range(1, 4)));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op("rand", rop, ra, rb, model(rop, ra, rb, hi_m, lo_m),
                   (rop == MD_MULT || rop == MD_MULTU) ? 5 : 10, 1'b0, 0);
        end

        // Reset in the middle of a MULT clears everything without a clock edge
        @(negedge clk);
        bus.start  = 1'b1;
        bus.md_op  = MD_MULT;
        bus.rs_val = 32'd7;
        bus.rt_val = 32'd9;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.md_op = MD_NONE;
        end
        #1;
        check("pre_rst_busy", 64'(bus.busy), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_hi", 64'(bus.hi), 64'(0));
        check("abort_lo", 64'(bus.lo), 64'(0));
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        reset = 1'b1;
        short_op("mtlo_after_rst", MD_MTLO, 32'h0000_ABCD);
        repeat (8) @(negedge clk);
        #1;
        check("post_rst_idle", 64'(bus.busy), 64'(0));
        check("post_rst_lo", 64'(bus.lo), 64'h0000_ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
